aes_key_sched_ctrl: RTL
=======================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have no parameters; all sizing is fixed by the AES standard and by the AES256_EN macro.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 init  input  1  single-cycle start pulse; it SHALL be sampled only while ready=1.
REQ-005 keylen  input  1  key length, 0=AES-128, 1=AES-256; it SHALL be sampled together with init.
REQ-006 key  input  256  cipher key; AES-128 SHALL use key[255:128] only.
REQ-007 round  input  4  round key read index.
REQ-008 round_key  output  128  round key at index round; combinational read of the key store.
REQ-009 ready  output  1  high when the block is idle and the key store is complete.
REQ-010 sboxw  output  32  word sent to the shared external S-box.
REQ-011 new_sboxw  input  32  S-box result for sboxw; it SHALL be combinational and valid in the same cycle.

Function
REQ-012 The FSM SHALL have the states IDLE, INIT, GEN and DONE.
REQ-013 In IDLE with init=1, the block SHALL latch key and keylen, go to INIT and drop ready in the next cycle.
REQ-014 INIT SHALL last one cycle: store round 0 as key[255:128] and set the 8-bit rcon register to 0x8d.
REQ-015 For AES-256 only, round 1 SHALL be stored as key[127:0] in the first GEN cycle.
REQ-016 GEN SHALL store exactly one round key per cycle at index k, for k=1..10 (AES-128) or k=2..14 (AES-256).
REQ-017 rcon update rule:
- new value = (rcon<<1) XOR (0x11b if rcon[7]=1), truncated to 8 bits.
- It SHALL update in every AES-128 GEN cycle and in every even-k AES-256 GEN cycle.
- Resulting sequence: 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x1b,0x36.
REQ-018 Rounds with rcon (AES-128 all k; AES-256 even k):
- sboxw = RotWord of the last word of round k-1.
- t = new_sboxw XOR {rcon_new,24'h0}.
REQ-019 Rounds without rcon (AES-256 odd k>=3):
- sboxw = the last word of round k-1, not rotated.
- t = new_sboxw.
REQ-020 Word recurrence, with p = round k-1 (AES-128) or round k-2 (AES-256):
- w0 = p.w0 XOR t.
- w1 = p.w1 XOR w0.
- w2 = p.w2 XOR w1.
- w3 = p.w3 XOR w2.
REQ-021 After the last key is written, the FSM SHALL pass through DONE for one cycle and then return to IDLE with ready=1.
REQ-022 Ready timing, counted from the cycle in which init is sampled:
- AES-128: ready SHALL be high again 13 cycles later.
- AES-256: ready SHALL be high again 17 cycles later.
REQ-023 init asserted while ready=0 SHALL be ignored, with no restart and no change to the latched key.
REQ-024 round_key SHALL return 128'h0 for round>10 (AES-128) and round=15 (AES-256).
REQ-025 Reads during generation SHALL return the current store contents, which may be stale from the previous expansion.
REQ-026 sboxw SHALL be 32'h0 outside GEN.

Reset
REQ-027 When reset_n=0 at a clock edge, the block SHALL set:
- FSM=IDLE, ready=1;
- rcon=0x00;
- all 15 key-store entries, the latched key and keylen cleared to 0;
- sboxw=0.
REQ-028 Reset mid-expansion SHALL abort immediately, and the next init SHALL start a clean expansion.

Configuration
REQ-029 Macro AES256_EN defined: keylen=1 SHALL select AES-256, and the key store SHALL hold 15 entries.
REQ-030 Macro AES256_EN undefined:
- keylen SHALL be ignored and treated as 0.
- The key store SHALL hold 11 entries.
- round>10 SHALL return 0.

Verification
REQ-031 FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, init, wait for ready:
- round 1 = a0fafe1788542cb123a339392a6c7605.
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 AES256_EN defined, FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen=1:
- round 14 = fe4890d1e6188d0b046df344706c631e.
- ready returns 17 cycles after init.
REQ-033 Monitor rcon during an AES-128 expansion -> sequence 0x8d,0x01,0x02,...,0x80,0x1b,0x36 in consecutive cycles.
REQ-034 Pulse init with a different key 3 cycles into GEN -> no effect, and the stored keys match the first key.
REQ-035 reset_n=0 for 1 cycle in mid-GEN -> ready=1 and round_key=0 for every index; a following init yields the correct A.1 keys.
REQ-036 AES256_EN undefined, keylen=1, A.1 key -> AES-128 results, and round=12 reads 0.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES key expansion controller driving a shared external S-box.
// Define AES256_EN to add AES-256 support (keylen=1) and the 15-entry key store;
// without it only AES-128 is built, keylen is ignored and the store holds 11 entries.
module aes_key_sched_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);
`ifdef AES256_EN
    localparam int   NK    = 15;
    localparam logic EN256 = 1'b1;
`else
    localparam int   NK    = 11;
    localparam logic EN256 = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_t;
    state_t       state;
    logic [127:0] store [NK];
    logic [255:0] key_q;
    logic         keylen_q;
    logic [7:0]   rcon;
    logic [7:0]   rcon_new;
    logic [3:0]   k;
    logic [3:0]   km1;
    logic [3:0]   km2;
    logic [3:0]   last;
    logic         use_rcon;
    logic         load_hi;
    logic [127:0] prev;
    logic [127:0] p;
    logic [31:0]  lastw;
    logic [31:0]  t;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;

    assign km1      = k - 4'd1;
    assign km2      = k - 4'd2;
    assign last     = keylen_q ? 4'd14 : 4'd10;
    // AES-256 odd rounds use SubWord only; the first AES-256 GEN cycle copies the key's low half
    assign use_rcon = !keylen_q || !k[0];
    assign load_hi  = keylen_q && k == 4'd1;
    assign prev     = store[km1];
    assign p        = keylen_q ? store[km2] : prev;
    assign lastw    = prev[31:0];
    assign rcon_new = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign sboxw    = state == GEN ? (use_rcon ? {lastw[23:0], lastw[31:24]} : lastw) : 32'h0;
    assign t        = new_sboxw ^ (use_rcon ? {rcon_new, 24'h0} : 32'h0);
    assign w0       = p[127:96] ^ t;
    assign w1       = p[95:64] ^ w0;
    assign w2       = p[63:32] ^ w1;
    assign w3       = p[31:0] ^ w2;
    // Entries beyond the active key length may hold stale AES-256 keys, so they read as zero
    assign round_key = round > last ? 128'h0 : store[round];

    // Expansion FSM: latch key, seed round 0 and rcon, then write one round key per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            rcon     <= 8'h00;
            key_q    <= '0;
            keylen_q <= 1'b0;
            k        <= 4'd0;
            for (int i = 0; i < NK; i++) store[i] <= '0;
        end else begin
            case (state)
                IDLE: if (init) begin
                    key_q    <= key;
                    keylen_q <= keylen & EN256;
                    ready    <= 1'b0;
                    state    <= INIT;
                end
                INIT: begin
                    store[0] <= key_q[255:128];
                    rcon     <= 8'h8d;
                    k        <= 4'd1;
                    state    <= GEN;
                end
                GEN: begin
                    store[k] <= load_hi ? key_q[127:0] : {w0, w1, w2, w3};
                    if (use_rcon) rcon <= rcon_new;
                    k <= k + 4'd1;
                    if (k == last) state <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
